// File: rtl/mem_sweep_ctrl.sv
// Sweep sequencer for one simple-dual-port block RAM: fills every word with a
// constant, or reads every word back and accumulates an additive checksum.
module mem_sweep_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4096,
    parameter int SUM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] fill_data,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  checksum,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // One extra counter bit so DEPTH == 2**ADDR_W never aliases back to zero.
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              at_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            sum_q   <= sum_d;
        end
    end

    assign at_last = (cnt_q == LAST_ADDR);

    // Command handshake: start is a strobe taken only in IDLE (no ready back);
    // mode and fill_data are sampled on that same edge, and start seen in any
    // other state is dropped rather than queued.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        sum_d   = sum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    fill_d = fill_data;
                    if (mode) begin
                        state_d = S_FILL;
                    end else begin
                        sum_d   = '0;
                        state_d = S_READ;
                    end
                end
            end
            S_FILL: begin
                cnt_d = cnt_q + 1'b1;
                if (at_last) state_d = S_DONE;
            end
            S_READ: begin
                cnt_d = cnt_q + 1'b1;
                // mem_dout lags the address by one cycle, so nothing is valid yet on the first READ cycle.
                if (cnt_q != '0) sum_d = sum_q + SUM_W'(mem_dout);
                if (at_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                sum_d   = sum_q + SUM_W'(mem_dout);
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == S_FILL) || (state_q == S_READ) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        mem_we    = (state_q == S_FILL);
        mem_din   = (state_q == S_FILL) ? fill_q : '0;
        mem_waddr = cnt_q[ADDR_W-1:0];
        mem_raddr = cnt_q[ADDR_W-1:0];
        checksum  = sum_q;
    end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Directed bench for mem_sweep_ctrl with a behavioural 4096x8 RAM holding a
// one-cycle registered read port.
module tb_mem_sweep_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4096;
  localparam int SUM_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] fill_data;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  checksum;
  logic [ADDR_W-1:0] mem_raddr;
  logic [DATA_W-1:0] mem_dout;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_din;
  logic              mem_we;
  logic              preload;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_sweep_ctrl #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .SUM_W (SUM_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode     (mode),
    .fill_data(fill_data),
    .busy     (busy),
    .done     (done),
    .checksum (checksum),
    .mem_raddr(mem_raddr),
    .mem_dout (mem_dout),
    .mem_waddr(mem_waddr),
    .mem_din  (mem_din),
    .mem_we   (mem_we)
  );

  // Memory model: word[i] = i[7:0] when preload is high, otherwise normal writes.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i);
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_din;
    end
    mem_dout <= mem[mem_raddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered 1 time unit after the accept edge; lat is the cycle index (accept
  // edge = 0) of the edge that samples done, 0 when done never came.
  task automatic wait_done(input int inj_at, output int lat, output int we_cnt);
    int k;
    k = 0;
    lat = 0;
    we_cnt = 0;
    while (k <= DEPTH + 10 && lat == 0) begin
      if (mem_we) we_cnt++;
      if (done) begin
        lat = k + 1;
      end else begin
        if (k == inj_at) begin
          start = 1'b1;
          mode  = 1'b1;
        end else if (k == inj_at + 1) begin
          start = 1'b0;
          mode  = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
    end
  endtask

  task automatic sweep(input logic m, input logic [7:0] d, input int inj_at,
                       output int lat, output int we_cnt);
    @(posedge clk); #1;
    start = 1'b1;
    mode = m;
    fill_data = d;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(inj_at, lat, we_cnt);
  endtask

  initial begin
    int lat;
    int we_cnt;
    int done_cnt;
    int exp_sum;

    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    fill_data = '0;
    preload = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_we", 32'(mem_we), 0);
    check("reset_checksum", 32'(checksum), 0);
    check("reset_raddr", 32'(mem_raddr), 0);
    check("reset_waddr", 32'(mem_waddr), 0);
    check("reset_din", 32'(mem_din), 0);
    reset = 1'b0;

    // Fill 0xA5, then check: 4096*0xA5 mod 2^16 = 0x5000.
    sweep(1'b1, 8'hA5, -10, lat, we_cnt);
    check("fill_a5_latency", 32'(lat), 4097);
    check("fill_a5_writes", 32'(we_cnt), 4096);
    sweep(1'b0, 8'h00, -10, lat, we_cnt);
    check("check_a5_latency", 32'(lat), 4098);
    check("check_a5_sum", 32'(checksum), 32'h5000);
    check("check_a5_no_we", 32'(we_cnt), 0);

    // Fill 0xFF wraps the accumulator: 4096*0xFF mod 2^16 = 0xF000.
    sweep(1'b1, 8'hFF, -10, lat, we_cnt);
    sweep(1'b0, 8'h00, -10, lat, we_cnt);
    check("check_ff_sum", 32'(checksum), 32'hF000);

    // A fill sweep leaves the previous checksum alone.
    sweep(1'b1, 8'h00, -10, lat, we_cnt);
    check("fill_keeps_sum", 32'(checksum), 32'hF000);
    sweep(1'b0, 8'h00, -10, lat, we_cnt);
    check("check_00_sum", 32'(checksum), 32'h0000);

    // word[i] = i[7:0]: 16*32640 mod 2^16 = 0xF800; a fill strobe at cycle 100 is ignored.
    @(posedge clk); #1;
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
    sweep(1'b0, 8'h00, 100, lat, we_cnt);
    check("check_ramp_latency", 32'(lat), 4098);
    check("check_ramp_sum", 32'(checksum), 32'hF800);
    check("check_ramp_no_we", 32'(we_cnt), 0);

    // Reset sampled on cycle 2000 of a 0x3C fill: addresses 0..1999 are written.
    @(posedge clk); #1;
    start = 1'b1;
    mode = 1'b1;
    fill_data = 8'h3C;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1999) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_we", 32'(mem_we), 0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_cnt++;
      @(posedge clk); #1;
    end
    check("abort_no_done", 32'(done_cnt), 0);
    exp_sum = 2000 * 32'h3C;
    for (int i = 2000; i < DEPTH; i++) exp_sum += i % 256;
    sweep(1'b0, 8'h00, -10, lat, we_cnt);
    check("abort_check_sum", 32'(checksum), 32'(exp_sum % 65536));

    // start and reset on the same edge: command dropped.
    @(posedge clk); #1;
    start = 1'b1;
    reset = 1'b1;
    mode = 1'b1;
    fill_data = 8'h77;
    @(posedge clk); #1;
    start = 1'b0;
    reset = 1'b0;
    check("start_reset_busy0", 32'(busy), 0);
    @(posedge clk); #1;
    check("start_reset_busy1", 32'(busy), 0);
    check("start_reset_we", 32'(mem_we), 0);

    // start held high: done, one IDLE cycle, then busy again.
    start = 1'b1;
    mode = 1'b1;
    fill_data = 8'h11;
    @(posedge clk); #1;
    wait_done(-10, lat, we_cnt);
    check("held_first_latency", 32'(lat), 4097);
    @(posedge clk); #1;
    check("held_idle_gap", 32'(busy), 0);
    @(posedge clk); #1;
    check("held_restart_busy", 32'(busy), 1);
    wait_done(-10, lat, we_cnt);
    start = 1'b0;
    check("held_second_latency", 32'(lat), 4097);
    sweep(1'b0, 8'h00, -10, lat, we_cnt);
    check("held_fill_sum", 32'(checksum), 32'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_sweep_ctrl.md
Name: mem_sweep_ctrl

Overview:
Sequencer for one simple-dual-port block RAM instance (1-cycle registered read, 4096x8 by default).
- On command it either fills every word with a constant, or reads every word back and reports a 16-bit additive checksum.
- It is used to re-initialise a RAM and to verify RAM contents after a bitstream memory reinit, without an external host walking addresses.
- It sits between the control logic and the memory, and owns the memory's address, data and write-enable inputs.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 8, memory word width
DEPTH, 4096, number of words swept (addresses 0..DEPTH-1), DEPTH <= 2**ADDR_W
SUM_W, 16, checksum width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  command strobe, sampled only in IDLE
mode  in  1  0 = check (read and sum), 1 = fill; sampled with start
fill_data  in  DATA_W  fill value; captured on accepted start
busy  out  1  high while a sweep is in progress
done  out  1  one-cycle pulse at sweep completion
checksum  out  SUM_W  check result; valid from done until the next accepted start
mem_raddr  out  ADDR_W  to memory read address
mem_dout  in  DATA_W  from memory; data for the address presented in the previous cycle
mem_waddr  out  ADDR_W  to memory write address
mem_din  out  DATA_W  to memory write data
mem_we  out  1  memory write enable; the memory instance paired with this block gates writes on it

Behaviour:
- Reset values:
  - state IDLE.
  - busy=0, done=0, mem_we=0, checksum=0.
  - mem_raddr=0, mem_waddr=0, mem_din=0.
  - Internal address counter and captured fill value are 0.
- States are IDLE, FILL, READ, DRAIN and DONE.
- IDLE:
  - An accepted start is start=1 in IDLE. It captures mode and fill_data.
  - It clears the counter to 0.
  - If mode=0 it also clears checksum to 0.
  - Next state is FILL (mode=1) or READ (mode=0).
- start outside IDLE is ignored: no restart, no queuing.
- FILL, one word per cycle for DEPTH cycles:
  - mem_we=1, mem_waddr=counter, mem_din=captured fill value.
  - The counter increments.
  - After address DEPTH-1 is written, go to DONE.
- READ, DEPTH cycles:
  - mem_raddr=counter, mem_we=0, and the counter increments.
  - From the second READ cycle onward, checksum <= checksum + mem_dout, mod 2**SUM_W.
  - After raddr=DEPTH-1 is issued, go to DRAIN.
- DRAIN, one cycle: accumulate the last word (address DEPTH-1), then go to DONE.
- DONE, one cycle: done=1, busy=0, then go to IDLE.
- busy=1 in FILL, READ and DRAIN; otherwise 0.
- Latency, with the start-accept edge as cycle 0:
  - Fill: writes occur in cycles 1..DEPTH; done occurs in cycle DEPTH+1.
  - Check: raddr 0..DEPTH-1 is issued in cycles 1..DEPTH; done occurs in cycle DEPTH+2.
- Arithmetic:
  - mem_dout is zero-extended to SUM_W before the add.
  - Overflow wraps silently.
- Counter wrap:
  - The counter is ADDR_W+1 bits wide, so DEPTH = 2**ADDR_W does not alias.
  - The terminal test is counter==DEPTH-1.
- checksum holds its value through DONE and IDLE.
  - A fill sweep does not modify checksum.
- mem_we=0 in every state except FILL, so no write occurs outside a fill sweep.
- Reset mid-sweep:
  - Abort immediately to the reset values; no done pulse.
  - Words already written stay written.
- start asserted in the same cycle as reset: reset wins, command dropped.
- start held high continuously: a new sweep is accepted on the first IDLE cycle after each DONE.

Test Plan:
- Reset, then fill with fill_data=0xA5, then check (DEPTH=4096): checksum=0x5000 at done; fill done exactly 4097 cycles after accept; check done exactly 4098 cycles after accept.
- Fill 0xFF then check: checksum=0xF000 (wrap exercised). Fill 0x00 then check: checksum=0x0000.
- Memory preloaded with word[i]=i[7:0], then check: checksum=(16*32640) mod 65536=0xF800; mem_we=0 on every cycle of the sweep.
- Pulse start with mode=1 at cycle 100 of a check sweep: ignored, mem_we stays 0, and the check completes with the original result.
- Assert reset at cycle 2000 of a fill with 0x3C: busy=0, mem_we=0 on the next cycle and no done. A subsequent check shows words 0..~1998 = 0x3C and the remaining words unchanged.
- Assert start and reset together: no sweep starts. Start held high: back-to-back sweeps, each done followed by busy=1 two cycles later.
